// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// The request side holds steady until mem_ack; mem_rdata is valid while mem_ack is high.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: accepts execute results, runs data-memory loads/stores, emits writeback.
// Optional BUSY timeout with mem_err pulse when MEMORY_STAGE_MEM_TIMEOUT_EN is defined.
module memory_stage (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [15:0]           ex_alu_out,
    input  logic [15:0]           ex_store_data,
    input  logic [2:0]            ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_reg_write,
    input  logic                  ex_flags_write,
    input  logic                  ex_carry,
    input  logic                  ex_neg,
    input  logic                  ex_zero,
    input  logic                  flush,
    memory_stage_if.master        mem_bus,
    output logic                  wb_valid,
    output logic [15:0]           wb_data,
    output logic [2:0]            wb_rd,
    output logic                  wb_reg_write,
    output logic [2:0]            ccr,
    output logic                  mem_err
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        is_load_q, is_load_d;
    logic        squash_q, squash_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [2:0]  ccr_q, ccr_d;
`ifdef MEMORY_STAGE_MEM_TIMEOUT_EN
    logic [3:0]  cnt_q, cnt_d;
    logic        mem_err_q, mem_err_d;
`endif

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        is_load_d      = is_load_q;
        squash_d       = squash_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        ccr_d          = ccr_q;
`ifdef MEMORY_STAGE_MEM_TIMEOUT_EN
        cnt_d          = cnt_q;
        mem_err_d      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // ex_ready is high in IDLE, so ex_valid alone means accept
                if (ex_valid && !flush) begin
                    if (ex_flags_write) begin
                        ccr_d = {ex_zero, ex_neg, ex_carry};
                    end
                    if (ex_mem_read || ex_mem_write) begin
                        state_d     = StBusy;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ex_mem_write;
                        mem_addr_d  = ex_alu_out;
                        mem_wdata_d = ex_store_data;
                        rd_d        = ex_rd;
                        reg_write_d = ex_reg_write;
                        is_load_d   = ex_mem_read;
`ifdef MEMORY_STAGE_MEM_TIMEOUT_EN
                        cnt_d       = 4'd0;
`endif
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_out;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_reg_write;
                    end
                end
            end
            StBusy: begin
                // A flush never aborts the bus access; it only suppresses the writeback
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (mem_bus.mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    squash_d  = 1'b0;
                    if (!(squash_q || flush)) begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = rd_q;
                        wb_reg_write_d = is_load_q && reg_write_q;
                        if (is_load_q) begin
                            wb_data_d = mem_bus.mem_rdata;
                        end
                    end
                end
`ifdef MEMORY_STAGE_MEM_TIMEOUT_EN
                else if (cnt_q == 4'd14) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    squash_d  = 1'b0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 16'h0000;
            mem_wdata_q    <= 16'h0000;
            rd_q           <= 3'd0;
            reg_write_q    <= 1'b0;
            is_load_q      <= 1'b0;
            squash_q       <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= 16'h0000;
            wb_rd_q        <= 3'd0;
            wb_reg_write_q <= 1'b0;
            ccr_q          <= 3'b000;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            is_load_q      <= is_load_d;
            squash_q       <= squash_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            ccr_q          <= ccr_d;
        end
    end

`ifdef MEMORY_STAGE_MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 4'd0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign ex_ready           = (state_q == StIdle);
    assign mem_bus.mem_req    = mem_req_q;
    assign mem_bus.mem_we     = mem_we_q;
    assign mem_bus.mem_addr   = mem_addr_q;
    assign mem_bus.mem_wdata  = mem_wdata_q;
    assign wb_valid           = wb_valid_q;
    assign wb_data            = wb_data_q;
    assign wb_rd              = wb_rd_q;
    assign wb_reg_write       = wb_reg_write_q;
    assign ccr                = ccr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage; inputs change and outputs are sampled 1ns after each rising edge.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [15:0] ex_alu_out, ex_store_data;
    logic [2:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_flags_write;
    logic        ex_carry, ex_neg, ex_zero, flush;
    logic        wb_valid, wb_reg_write, mem_err;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd, ccr;

    int n_cmp = 0;
    int n_err = 0;

    memory_stage_if mem_bus ();

    memory_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_out     (ex_alu_out),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_flags_write (ex_flags_write),
        .ex_carry       (ex_carry),
        .ex_neg         (ex_neg),
        .ex_zero        (ex_zero),
        .flush          (flush),
        .mem_bus        (mem_bus),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .ccr            (ccr),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                         input logic [2:0] rd, input logic mr, input logic mw, input logic rw,
                         input logic fw, input logic z, input logic n, input logic c);
        ex_valid = v; ex_alu_out = alu; ex_store_data = sd; ex_rd = rd;
        ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_flags_write = fw;
        ex_zero = z; ex_neg = n; ex_carry = c;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Reset state
        check("rst ex_ready", ex_ready, 1);
        check("rst mem_req", mem_bus.mem_req, 0);
        check("rst mem_we", mem_bus.mem_we, 0);
        check("rst mem_addr", mem_bus.mem_addr, 0);
        check("rst mem_wdata", mem_bus.mem_wdata, 0);
        check("rst wb_valid", wb_valid, 0);
        check("rst wb_data", wb_data, 0);
        check("rst wb_rd", wb_rd, 0);
        check("rst wb_reg_write", wb_reg_write, 0);
        check("rst ccr", ccr, 0);
        check("rst mem_err", mem_err, 0);
        rst = 1'b1;
        step();

        // ALU op: one-cycle latency, flags loaded
        drive(1'b1, 16'h1234, 16'h0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu wb_valid", wb_valid, 1);
        check("alu wb_data", wb_data, 16'h1234);
        check("alu wb_rd", wb_rd, 5);
        check("alu wb_reg_write", wb_reg_write, 1);
        check("alu ccr", ccr, 3'b001);
        check("alu ex_ready", ex_ready, 1);
        step();
        check("alu pulse end", wb_valid, 0);
        check("alu data hold", wb_data, 16'h1234);

        // Load with three wait cycles
        drive(1'b1, 16'h0040, 16'h0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ld mem_req", mem_bus.mem_req, 1);
            check("ld mem_we", mem_bus.mem_we, 0);
            check("ld mem_addr", mem_bus.mem_addr, 16'h0040);
            check("ld ex_ready", ex_ready, 0);
            check("ld no wb", wb_valid, 0);
            if (i == 3) begin
                mem_bus.mem_ack = 1'b1;
                mem_bus.mem_rdata = 16'hBEEF;
            end
            step();
        end
        mem_bus.mem_ack = 1'b0;
        check("ld wb_valid", wb_valid, 1);
        check("ld wb_data", wb_data, 16'hBEEF);
        check("ld wb_rd", wb_rd, 3);
        check("ld wb_reg_write", wb_reg_write, 1);
        check("ld mem_req drop", mem_bus.mem_req, 0);
        check("ld ccr hold", ccr, 3'b001);
        step();
        check("ld pulse end", wb_valid, 0);

        // Store flushed in second BUSY cycle
        drive(1'b1, 16'h0010, 16'hA5A5, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("st mem_we", mem_bus.mem_we, 1);
        check("st mem_addr", mem_bus.mem_addr, 16'h0010);
        check("st mem_wdata", mem_bus.mem_wdata, 16'hA5A5);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("st req after flush", mem_bus.mem_req, 1);
        check("st we after flush", mem_bus.mem_we, 1);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        check("st squashed wb", wb_valid, 0);
        check("st req drop", mem_bus.mem_req, 0);
        check("st ex_ready", ex_ready, 1);
        check("st data hold", wb_data, 16'hBEEF);
        step();
        check("st still no wb", wb_valid, 0);

        // Zero-wait load, then ALU op presented while BUSY
        drive(1'b1, 16'h0080, 16'h0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("b2b busy", ex_ready, 0);
        drive(1'b1, 16'h5555, 16'h0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 16'hCAFE;
        step();
        mem_bus.mem_ack = 1'b0;
        check("b2b ld wb_valid", wb_valid, 1);
        check("b2b ld wb_data", wb_data, 16'hCAFE);
        check("b2b ld wb_rd", wb_rd, 4);
        check("b2b ready", ex_ready, 1);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b alu wb_valid", wb_valid, 1);
        check("b2b alu wb_data", wb_data, 16'h5555);
        check("b2b alu wb_rd", wb_rd, 6);
        check("b2b alu ccr", ccr, 3'b100);
        step();
        check("b2b pulse end", wb_valid, 0);

        // Flush in accept cycle: no writeback, no flags, no request
        drive(1'b1, 16'h7777, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        check("fl alu wb_valid", wb_valid, 0);
        check("fl alu ccr", ccr, 3'b100);
        check("fl alu wb_data", wb_data, 16'h5555);
        drive(1'b1, 16'h0020, 16'h1111, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fl st mem_req", mem_bus.mem_req, 0);
        check("fl st ready", ex_ready, 1);
        check("fl st ccr", ccr, 3'b100);

        // Ack while IDLE is ignored
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 16'h1111;
        step();
        mem_bus.mem_ack = 1'b0;
        check("idle ack wb_valid", wb_valid, 0);
        check("idle ack wb_data", wb_data, 16'h5555);
        check("idle ack ready", ex_ready, 1);

`ifdef MEMORY_STAGE_MEM_TIMEOUT_EN
        // Load never acknowledged: 15 BUSY cycles then timeout
        drive(1'b1, 16'h0090, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            check("to mem_req", mem_bus.mem_req, 1);
            check("to mem_err low", mem_err, 0);
            step();
        end
        check("to mem_req drop", mem_bus.mem_req, 0);
        check("to mem_err", mem_err, 1);
        check("to ready", ex_ready, 1);
        check("to no wb", wb_valid, 0);
        step();
        check("to mem_err pulse", mem_err, 0);
`else
        // Without the timeout BUSY persists
        drive(1'b1, 16'h0090, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check("nt mem_req", mem_bus.mem_req, 1);
        check("nt ready", ex_ready, 0);
        check("nt mem_err", mem_err, 0);
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 16'h2222;
        step();
        mem_bus.mem_ack = 1'b0;
        check("nt wb_data", wb_data, 16'h2222);
        check("nt wb_valid", wb_valid, 1);
`endif

        // Asynchronous reset mid-access
        drive(1'b1, 16'h00A0, 16'h0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ar req before", mem_bus.mem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar req async drop", mem_bus.mem_req, 0);
        check("ar ready", ex_ready, 1);
        check("ar ccr", ccr, 0);
        check("ar wb_data", wb_data, 0);
        step();
        rst = 1'b1;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 16'h3333;
        step();
        mem_bus.mem_ack = 1'b0;
        check("ar lost wb_valid", wb_valid, 0);
        check("ar lost wb_data", wb_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
